instruction_queue: RTL and testbench

- Issue-side FIFO between the control unit's decoder and the execution units (math, cache/regfile load-store, DMA).
- Each write pushes one "vector" instruction that is replayed copy_count+1 times. Each replay advances the addresses by programmed strides.
- Pops one expanded copy per read and presents it on the output bus matching its instruction type.
- Raises a sticky error flag on overflow or underflow.

---
 rtl/instruction_queue_pkg.sv | 30 +++
 rtl/instruction_queue_varray.sv | 73 +++++++
 rtl/instruction_queue.sv | 173 +++++++++++++++++
 tb/tb_instruction_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_queue_pkg.sv
// Shared types and constants for the issue-side instruction queue.
// Bus layouts match the execution-unit interfaces (first field is the MSB).
package instruction_queue_pkg;

  localparam int ADDR_W = 18;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd0;
  localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'd1;
  localparam logic [1:0] INSTR_TYPE_RAM        = 2'd2;
  localparam logic [1:0] INSTR_TYPE_RESERVED   = 2'd3;

  typedef struct packed {
    logic [8:0] ram_op;
    addr_t      main_mem_addr;
    addr_t      cache_addr;
  } dma_instruction;

  typedef struct packed {
    logic [9:0] arith_op;
    addr_t      cache_addr;
  } math_instr;

  typedef struct packed {
    logic [9:0] ld_st_op;
    addr_t      cache_addr;
  } regfile_instruction;

endpackage

// File: rtl/instruction_queue_varray.sv
// Circular entry store with head/tail pointers and occupancy tracking.
// Callers must only push when not full and only pop when not empty.
module instruction_queue_varray #(
  parameter int DATA_W    = 88,
  parameter int LOG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int CNT_W = LOG_DEPTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] head_q, head_d;
  logic [LOG_DEPTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 empty_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) begin
      tail_d = tail_q + LOG_DEPTH'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_i) begin
      head_d = head_q + LOG_DEPTH'(1);
    end else begin
      head_d = head_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= {LOG_DEPTH{1'b0}};
      tail_q  <= {LOG_DEPTH{1'b0}};
      count_q <= {CNT_W{1'b0}};
      empty_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= (count_d == {CNT_W{1'b0}});
    end
  end

  // Storage needs no reset: pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[head_q];
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = empty_q;

endmodule

// File: rtl/instruction_queue.sv
// Vector instruction issue queue: each entry is replayed copy_count+1 times
// with strided addresses, one copy per pop, as a one-cycle output pulse.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int LOG_SUPERSCALAR_WIDTH = 4,
  parameter int LOG_DEPTH             = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             re,
  output logic [44:0]                      out_dma_instr,
  output logic [27:0]                      out_math_instr,
  output logic [27:0]                      out_cache_instr,
  output logic                             empty,
  input  logic                             we,
  input  logic [1:0]                       in_instr_type,
  input  logic [LOG_SUPERSCALAR_WIDTH-1:0] copy_count,
  input  logic [ADDR_W-1:0]                cache_addr,
  input  logic [ADDR_W-1:0]                main_mem_addr,
  input  logic [ADDR_W-1:0]                d_cache_addr,
  input  logic [ADDR_W-1:0]                d_main_mem_addr,
  input  logic [0:9]                       in_arith_instr,
  input  logic [0:8]                       in_ram_instr,
  input  logic [0:9]                       in_ld_st_instr,
  output logic                             needs_reset
);

  localparam int CW = LOG_SUPERSCALAR_WIDTH;

  typedef struct packed {
    logic [1:0]    itype;
    logic [CW-1:0] copy_count;
    logic [9:0]    opcode;
    addr_t         cache_addr;
    addr_t         main_addr;
    addr_t         d_cache;
    addr_t         d_main;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t             wentry_s;
  entry_t             head_s;
  logic [ENTRY_W-1:0] head_bits_s;
  logic               full_s, empty_s;
  logic               push_ok_s, pop_ok_s, retire_s, err_s;
  addr_t              cur_cache_s, cur_main_s;

  logic [CW-1:0]      copy_idx_q, copy_idx_d;
  addr_t              off_c_q, off_c_d;
  addr_t              off_m_q, off_m_d;
  dma_instruction     dma_q, dma_d;
  math_instr          math_q, math_d;
  regfile_instruction ls_q, ls_d;
  logic               needs_reset_q, needs_reset_d;

  // Only the opcode of the selected type is kept; RAM opcodes are zero-extended.
  always_comb begin
    wentry_s            = '0;
    wentry_s.itype      = in_instr_type;
    wentry_s.copy_count = copy_count;
    wentry_s.cache_addr = cache_addr;
    wentry_s.main_addr  = main_mem_addr;
    wentry_s.d_cache    = d_cache_addr;
    wentry_s.d_main     = d_main_mem_addr;
    case (in_instr_type)
      INSTR_TYPE_ARITHMETIC: wentry_s.opcode = in_arith_instr;
      INSTR_TYPE_LOAD_STORE: wentry_s.opcode = in_ld_st_instr;
      INSTR_TYPE_RAM:        wentry_s.opcode = {1'b0, in_ram_instr};
      default:               wentry_s.opcode = 10'd0;
    endcase
  end

  // Full is judged on the pre-pop occupancy, so a same-cycle pop frees no slot.
  assign push_ok_s = we & ~full_s & (in_instr_type != INSTR_TYPE_RESERVED);
  assign pop_ok_s  = re & ~empty_s;
  assign retire_s  = pop_ok_s & (copy_idx_q == head_s.copy_count);
  assign err_s     = (re & empty_s) | (we & full_s) |
                     (we & (in_instr_type == INSTR_TYPE_RESERVED));

  instruction_queue_varray #(
    .DATA_W    (ENTRY_W),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_varray (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_ok_s),
    .pop_i   (retire_s),
    .wdata_i (wentry_s),
    .head_o  (head_bits_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign head_s = entry_t'(head_bits_s);

  // Offsets accumulate k*stride; adding to the base avoids a multiplier.
  assign cur_cache_s = head_s.cache_addr + off_c_q;
  assign cur_main_s  = head_s.main_addr + off_m_q;

  always_comb begin
    copy_idx_d    = copy_idx_q;
    off_c_d       = off_c_q;
    off_m_d       = off_m_q;
    dma_d         = '0;
    math_d        = '0;
    ls_d          = '0;
    needs_reset_d = needs_reset_q | err_s;
    if (pop_ok_s) begin
      case (head_s.itype)
        INSTR_TYPE_ARITHMETIC: begin
          math_d.arith_op   = head_s.opcode;
          math_d.cache_addr = cur_cache_s;
        end
        INSTR_TYPE_LOAD_STORE: begin
          ls_d.ld_st_op   = head_s.opcode;
          ls_d.cache_addr = cur_cache_s;
        end
        INSTR_TYPE_RAM: begin
          dma_d.ram_op        = head_s.opcode[8:0];
          dma_d.main_mem_addr = cur_main_s;
          dma_d.cache_addr    = cur_cache_s;
        end
        default: begin
          dma_d  = '0;
          math_d = '0;
          ls_d   = '0;
        end
      endcase
      if (retire_s) begin
        copy_idx_d = {CW{1'b0}};
        off_c_d    = {ADDR_W{1'b0}};
        off_m_d    = {ADDR_W{1'b0}};
      end else begin
        copy_idx_d = copy_idx_q + CW'(1);
        off_c_d    = off_c_q + head_s.d_cache;
        off_m_d    = off_m_q + head_s.d_main;
      end
    end else begin
      copy_idx_d = copy_idx_q;
      off_c_d    = off_c_q;
      off_m_d    = off_m_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      copy_idx_q    <= {CW{1'b0}};
      off_c_q       <= {ADDR_W{1'b0}};
      off_m_q       <= {ADDR_W{1'b0}};
      dma_q         <= '0;
      math_q        <= '0;
      ls_q          <= '0;
      needs_reset_q <= 1'b0;
    end else begin
      copy_idx_q    <= copy_idx_d;
      off_c_q       <= off_c_d;
      off_m_q       <= off_m_d;
      dma_q         <= dma_d;
      math_q        <= math_d;
      ls_q          <= ls_d;
      needs_reset_q <= needs_reset_d;
    end
  end

  assign out_dma_instr   = dma_q;
  assign out_math_instr  = math_q;
  assign out_cache_instr = ls_q;
  assign empty           = empty_s;
  assign needs_reset     = needs_reset_q;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue.
module tb_instruction_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [44:0] out_dma_instr;
  logic [27:0] out_math_instr;
  logic [27:0] out_cache_instr;
  logic        empty;
  logic        needs_reset;
  logic [1:0]  in_instr_type = 2'd0;
  logic [3:0]  copy_count = 4'd0;
  logic [17:0] cache_addr = 18'd0;
  logic [17:0] main_mem_addr = 18'd0;
  logic [17:0] d_cache_addr = 18'd0;
  logic [17:0] d_main_mem_addr = 18'd0;
  logic [0:9]  in_arith_instr = 10'd0;
  logic [0:8]  in_ram_instr = 9'd0;
  logic [0:9]  in_ld_st_instr = 10'd0;

  int passed = 0;
  int total = 0;
  logic [17:0] ea;

  instruction_queue dut (
    .clk             (clk),
    .reset           (reset),
    .re              (re),
    .out_dma_instr   (out_dma_instr),
    .out_math_instr  (out_math_instr),
    .out_cache_instr (out_cache_instr),
    .empty           (empty),
    .we              (we),
    .in_instr_type   (in_instr_type),
    .copy_count      (copy_count),
    .cache_addr      (cache_addr),
    .main_mem_addr   (main_mem_addr),
    .d_cache_addr    (d_cache_addr),
    .d_main_mem_addr (d_main_mem_addr),
    .in_arith_instr  (in_arith_instr),
    .in_ram_instr    (in_ram_instr),
    .in_ld_st_instr  (in_ld_st_instr),
    .needs_reset     (needs_reset)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we = 1'b0;
    re = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_entry(input logic [1:0] t, input logic [3:0] cc, input logic [9:0] op,
                           input logic [17:0] ca, input logic [17:0] ma,
                           input logic [17:0] dc, input logic [17:0] dm);
    in_instr_type   = t;
    copy_count      = cc;
    in_arith_instr  = op;
    in_ld_st_instr  = op;
    in_ram_instr    = op[8:0];
    cache_addr      = ca;
    main_mem_addr   = ma;
    d_cache_addr    = dc;
    d_main_mem_addr = dm;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_dma", out_dma_instr, 45'd0);
    chk("rst_math", out_math_instr, 28'd0);
    chk("rst_cache", out_cache_instr, 28'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_nr", needs_reset, 1'b0);

    // Underflow
    re = 1'b1;
    tick();
    re = 1'b0;
    chk("uf_math", out_math_instr, 28'd0);
    chk("uf_dma", out_dma_instr, 45'd0);
    chk("uf_empty", empty, 1'b1);
    chk("uf_nr", needs_reset, 1'b1);

    // 16-copy arithmetic expansion
    do_reset();
    chk("post_rst_nr", needs_reset, 1'b0);
    set_entry(2'd0, 4'd15, 10'h200, 18'h100, 18'h0, 18'd4, 18'd0);
    we = 1'b1;
    tick();
    we = 1'b0;
    chk("wr_empty", empty, 1'b0);
    re = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      ea = 18'h100 + 18'(k * 4);
      chk("vec_math", out_math_instr, {10'h200, ea});
      chk("vec_dma0", out_dma_instr, 45'd0);
      chk("vec_cache0", out_cache_instr, 28'd0);
    end
    chk("vec_empty", empty, 1'b1);
    re = 1'b0;
    tick();
    chk("vec_pulse_end", out_math_instr, 28'd0);
    chk("vec_nr", needs_reset, 1'b0);

    // RAM entry with main-address wrap, then a load/store entry
    set_entry(2'd2, 4'd1, 10'h1A5, 18'h0, 18'h3FFFF, 18'd2, 18'd1);
    we = 1'b1;
    tick();
    set_entry(2'd1, 4'd0, 10'h3C1, 18'h55, 18'h0, 18'd0, 18'd0);
    tick();
    we = 1'b0;
    re = 1'b1;
    tick();
    chk("dma_c0", out_dma_instr, {9'h1A5, 18'h3FFFF, 18'h0});
    chk("dma_c0_math", out_math_instr, 28'd0);
    tick();
    chk("dma_c1_wrap", out_dma_instr, {9'h1A5, 18'h00000, 18'h2});
    tick();
    chk("ls_c0", out_cache_instr, {10'h3C1, 18'h55});
    chk("ls_c0_dma", out_dma_instr, 45'd0);
    chk("ls_empty", empty, 1'b1);
    re = 1'b0;
    tick();
    chk("ls_pulse_end", out_cache_instr, 28'd0);

    // Overflow: 16 entries fill the queue, the 17th is dropped
    do_reset();
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_entry(2'd0, 4'd0, 10'(i + 1), 18'(i * 16), 18'h0, 18'd0, 18'd0);
      tick();
    end
    chk("full_nr", needs_reset, 1'b0);
    set_entry(2'd0, 4'd0, 10'h3FF, 18'h3FFFF, 18'h0, 18'd0, 18'd0);
    tick();
    we = 1'b0;
    chk("ovf_nr", needs_reset, 1'b1);
    re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain", out_math_instr, {10'(i + 1), 18'(i * 16)});
    end
    re = 1'b0;
    chk("drain_empty", empty, 1'b1);
    tick();
    chk("drain_no17", out_math_instr, 28'd0);

    // Simultaneous write and read
    do_reset();
    set_entry(2'd0, 4'd0, 10'h011, 18'h10, 18'h0, 18'd0, 18'd0);
    we = 1'b1;
    tick();
    set_entry(2'd0, 4'd0, 10'h022, 18'h20, 18'h0, 18'd0, 18'd0);
    re = 1'b1;
    tick();
    we = 1'b0;
    chk("sim_old", out_math_instr, {10'h011, 18'h10});
    chk("sim_empty", empty, 1'b0);
    tick();
    re = 1'b0;
    chk("sim_new", out_math_instr, {10'h022, 18'h20});
    chk("sim_empty_end", empty, 1'b1);
    chk("sim_nr", needs_reset, 1'b0);

    // Reset during a partially drained entry
    set_entry(2'd0, 4'd3, 10'h005, 18'h0, 18'h0, 18'd1, 18'd0);
    we = 1'b1;
    tick();
    we = 1'b0;
    re = 1'b1;
    tick();
    chk("part_c0", out_math_instr, {10'h005, 18'h0});
    do_reset();
    chk("part_rst_empty", empty, 1'b1);
    chk("part_rst_math", out_math_instr, 28'd0);
    chk("part_rst_nr", needs_reset, 1'b0);
    re = 1'b1;
    tick();
    re = 1'b0;
    chk("part_re_math", out_math_instr, 28'd0);
    chk("part_re_nr", needs_reset, 1'b1);

    // Copy index and offsets restart cleanly after reset
    do_reset();
    set_entry(2'd0, 4'd1, 10'h007, 18'h40, 18'h0, 18'd8, 18'd0);
    we = 1'b1;
    tick();
    we = 1'b0;
    re = 1'b1;
    tick();
    chk("restart_c0", out_math_instr, {10'h007, 18'h40});
    tick();
    chk("restart_c1", out_math_instr, {10'h007, 18'h48});
    re = 1'b0;
    chk("restart_empty", empty, 1'b1);

    // Reserved type is dropped and flagged
    do_reset();
    set_entry(2'd3, 4'd0, 10'h0AA, 18'h1, 18'h0, 18'd0, 18'd0);
    we = 1'b1;
    tick();
    we = 1'b0;
    chk("rsv_empty", empty, 1'b1);
    chk("rsv_nr", needs_reset, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
